// File: rtl/e_mem_reader_pkg.sv
// ---------------------------------------------------------------------------
// e_mem_reader_pkg
// Shared definitions for the E_MEM read master and its skid FIFO.
//   REG_SIZE : width of address, length and data words (build-wide macro)
//   MEM_SIZE : number of words in E_MEM (build-wide macro)
// Reader FSM encodings, FIFO depth and the address-advance helper live here.
// Optional feature macro: E_MEM_READER_WRAP_EN (address wraps at MEM_SIZE-1).
// ---------------------------------------------------------------------------
`ifndef REG_SIZE
`define REG_SIZE 16
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 64
`endif

package e_mem_reader_pkg;

  localparam int REG_W      = `REG_SIZE;
  localparam int MEM_WORDS  = `MEM_SIZE;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Address following 'a'. With wrapping enabled the last memory word is
  // followed by word 0; otherwise the counter simply rolls over 2^REG_W.
  function automatic logic [REG_W-1:0] next_addr(input logic [REG_W-1:0] a);
`ifdef E_MEM_READER_WRAP_EN
    return (a == REG_W'(MEM_WORDS - 1)) ? '0 : a + REG_W'(1);
`else
    return a + REG_W'(1);
`endif
  endfunction

endpackage

// File: rtl/e_mem_skid_fifo.sv
// ---------------------------------------------------------------------------
// e_mem_skid_fifo
// Two-entry FIFO that absorbs read data still in flight when the consumer
// stalls. Push and pop in the same cycle are both honoured.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (flushes the FIFO)
//   push_i        : write push_data_i (never asserted while full)
//   push_data_i   : entry to store
//   pop_i         : remove head entry (only asserted while head_valid_o)
//   head_data_o   : current head entry
//   head_valid_o  : FIFO not empty
//   occupancy_o   : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module e_mem_skid_fifo
  import e_mem_reader_pkg::*;
#(
  parameter int W = REG_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_data_o,
  output logic         head_valid_o,
  output logic [1:0]   occupancy_o
);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values; storage is cleared on reset as well, because the head
  // entry is visible on m_data and must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data_o  = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != 2'd0);
  assign occupancy_o  = count_q;

endmodule

// File: rtl/e_mem_reader.sv
// ---------------------------------------------------------------------------
// e_mem_reader
// Read master for E_MEM: on start it walks length words from base_addr,
// drives mem_address, captures the 1-cycle-latency mem_data and presents it
// as a valid/ready stream through a 2-entry skid FIFO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : command strobe (ignored while busy)
//   base_addr, length   : command, sampled with start
//   busy                : transfer in progress
//   done                : 1-cycle pulse when the last word has been accepted
//   err                 : 1-cycle pulse when a command is rejected
//   mem_address         : E_MEM address port
//   mem_data            : E_MEM registered read data
//   m_valid/m_ready     : output stream handshake
//   m_data, m_last      : stream word, final-word marker
// Macro E_MEM_READER_WRAP_EN: defined -> addresses wrap at MEM_SIZE and every
// command is accepted; undefined -> out-of-range commands are rejected.
// ---------------------------------------------------------------------------
module e_mem_reader
  import e_mem_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REG_W-1:0] base_addr,
  input  logic [REG_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REG_W-1:0] mem_address,
  input  logic [REG_W-1:0] mem_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [REG_W-1:0] m_data,
  output logic             m_last
);

  state_e           state_q, state_d;
  logic [REG_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0] len_q, len_d;
  logic [REG_W-1:0] issued_q, issued_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             inflight_q;
  logic             inflight_last_q;

  logic             pop;
  logic             issue;
  logic             issue_last;
  logic             reject;
  logic [1:0]       occupancy;
  logic [REG_W:0]   head;

  assign pop = m_valid & m_ready;

  // Room check (occupancy + inflight - pop < 2), rearranged to avoid
  // unsigned underflow.
  assign issue = (state_q == ST_RUN) && (issued_q != len_q) &&
                 (({1'b0, occupancy} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign issue_last = (issued_q == len_q - REG_W'(1));

`ifdef E_MEM_READER_WRAP_EN
  assign reject = 1'b0;
`else
  logic [REG_W:0] end_addr;
  assign end_addr = {1'b0, base_addr} + {1'b0, length};
  assign reject   = ({1'b0, base_addr} >= (REG_W+1)'(MEM_WORDS)) ||
                    (end_addr > (REG_W+1)'(MEM_WORDS));
`endif

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (reject) begin
            err_d = 1'b1;
          end else if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d   = base_addr;
            len_d    = length;
            issued_d = '0;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d   = next_addr(addr_q);
          issued_d = issued_q + REG_W'(1);
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      done_q          <= done_d;
      err_q           <= err_d;
      // The word addressed this cycle appears on mem_data next cycle.
      inflight_q      <= issue;
      inflight_last_q <= issue & issue_last;
    end
  end

  e_mem_skid_fifo #(.W(REG_W + 1)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, mem_data}),
    .pop_i       (pop),
    .head_data_o (head),
    .head_valid_o(m_valid),
    .occupancy_o (occupancy)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign mem_address = addr_q;
  assign m_data      = head[REG_W-1:0];
  assign m_last      = head[REG_W] & m_valid;

endmodule

// File: tb/tb_e_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_e_mem_reader
// Self-checking bench for e_mem_reader. A behavioural E_MEM responder holds
// word i = i + 0x10. Commands push their expected beats into a queue; an
// independent monitor pops and compares on every accepted beat.
// ---------------------------------------------------------------------------
module tb_e_mem_reader;
  import e_mem_reader_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [REG_W-1:0] base_addr;
  logic [REG_W-1:0] length;
  logic             busy, done, err;
  logic [REG_W-1:0] mem_address;
  logic [REG_W-1:0] mem_data;
  logic             m_valid, m_ready, m_last;
  logic [REG_W-1:0] m_data;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [REG_W-1:0] data;
    logic             last;
  } beat_t;
  beat_t exp_q[$];

  logic [REG_W-1:0] image [MEM_WORDS];

  always #5 clk = ~clk;

  e_mem_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  // E_MEM responder: registered read, one cycle latency.
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) image[i] = REG_W'(i + 16);
  end
  always @(posedge clk) begin
    if (int'(mem_address) < MEM_WORDS) mem_data <= image[int'(mem_address)];
    else                               mem_data <= '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats for an accepted command, straight from the addressing rule.
  task automatic push_expected(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = REG_W'(((base + i) % MEM_WORDS) + 16);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: compares every accepted beat and checks stall stability.
  initial begin
    logic             prev_stall;
    logic [REG_W-1:0] prev_data;
    logic             prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (prev_stall) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, prev_data);
        check("stall_last_held", m_last, prev_last);
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_data, 32'hdead);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
        end
      end
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0) && (rst === 1'b0);
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2 == 0);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Issue one command and follow it to completion with a bounded wait.
  // repulse > 0 re-strobes start (with different operands) in that cycle.
  task automatic do_cmd(input int base, input int len, input int mode, input int repulse);
    bit rejected;
    bit err_later;
    int stalls;
    int done_at;
    int dc0;
    stalls    = 0;
    done_at   = -1;
    err_later = 1'b0;
`ifdef E_MEM_READER_WRAP_EN
    rejected = 1'b0;
`else
    rejected = (base >= MEM_WORDS) || (base + len > MEM_WORDS);
`endif
    if (!rejected) push_expected(base, len);
    dc0 = done_cnt;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = REG_W'(base);
    length    = REG_W'(len);
    m_ready   = ready_for(mode, 0);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      start = (c == repulse);
      if (c == repulse) begin
        base_addr = REG_W'(base + 7);
        length    = REG_W'(len + 3);
      end
      m_ready = ready_for(mode, c);
      if (c == 1) begin
        check("err_cycle1", err, rejected);
        check("busy_cycle1", busy, (!rejected && len > 0));
      end else if (err) begin
        err_later = 1'b1;
      end
      if (m_valid && !m_ready) stalls++;
      if (done) begin
        done_at = c;
        break;
      end
      if (rejected && c == 6) break;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    check("no_late_err", err_later, 0);
    if (rejected)      check("rejected_no_done", done_cnt - dc0, 0);
    else if (len == 0) check("len0_done_cycle", done_at, 1);
    else               check("done_cycle", done_at, len + 3 + stalls);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_cnt - dc0, rejected ? 0 : 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int dc_before;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cycle-exact transfer: base 0, length 4, consumer always ready.
    push_expected(0, 4);
    start     = 1'b1;
    base_addr = '0;
    length    = REG_W'(4);
    m_ready   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k <= 4) check("t1_mem_address", mem_address, k - 1);
      check("t1_m_valid", m_valid, (k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) check("t1_m_data", m_data, 16 + k - 3);
      check("t1_m_last", m_last, (k == 6));
      check("t1_done", done, (k == 7));
      check("t1_busy", busy, (k <= 6));
    end
    repeat (2) @(posedge clk);

    // Toggling consumer.
    do_cmd(8, 6, 1, 0);
    // Zero length.
    do_cmd(5, 0, 0, 0);
    // Crossing the end of memory (rejected, or wraps when enabled).
    do_cmd(MEM_WORDS - 2, 4, 0, 0);
    // Start re-pulsed mid-transfer.
    do_cmd(4, 5, 0, 3);

    // Reset on the third beat of a length-10 transfer.
    push_expected(0, 10);
    dc_before = done_cnt;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = '0;
    length    = REG_W'(10);
    m_ready   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst_third_beat", m_data, 16 + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_mem_address", mem_address, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_m_last", m_last, 0);
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - dc_before, 0);
    check("mid_rst_idle_valid", m_valid, 0);
    do_cmd(0, 2, 0, 0);

    // Random in-range commands with a randomly stalling consumer.
    for (int n = 0; n < 8; n++) begin
      int b;
      int l;
      b = $urandom_range(0, MEM_WORDS - 1);
      l = $urandom_range(1, MEM_WORDS - b);
      if (l > 12) l = 12;
      do_cmd(b, l, 2, (n % 3 == 0) ? 4 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/e_mem_reader.md
# e_mem_reader

Read master for the image memory block `E_MEM`: on a start command it issues sequential addresses to the memory's address port and turns the 1-cycle-latency registered read data into a valid/ready output stream. It sits between `E_MEM` and downstream processing. A 2-entry skid buffer lets the consumer stall at any cycle without losing in-flight reads, while sustaining one word per cycle when it does not stall.

## Interface
- `REG_SIZE`: package macro, no local default. Width of address, length and data.
- `MEM_SIZE`: package macro, no local default. Number of memory words.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle command strobe
- base_addr  in  `REG_SIZE  first word address, sampled with start
- length  in  `REG_SIZE  word count, sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- err  out  1  one-cycle pulse on rejected command
- mem_address  out  `REG_SIZE  address to `E_MEM`
- mem_data  in  `REG_SIZE  `E_MEM` data_out, valid 1 cycle after address
- m_valid  out  1  stream data valid
- m_ready  in  1  consumer accepts
- m_data  out  `REG_SIZE  stream word
- m_last  out  1  marks final word of transfer

## Operation
- FSM states:
  - IDLE: on start with busy=0, latch base_addr/length and go to RUN.
  - RUN: issue reads until `length` words have been issued, then go to DRAIN.
  - DRAIN: wait until all words are accepted, pulse done, go to IDLE.
- start while busy=1 is ignored; it causes no err.
- length=0: busy stays 0, done pulses the cycle after start, no beats are sent.
- Read issue rule: a read is issued when (occupancy + inflight − pop) < 2. Pop = m_valid & m_ready in the same cycle.
- Each issued read increments mem_address. An inflight flag marks data arriving on mem_data next cycle; that word is pushed into the skid FIFO.
- FIFO: 2 entries; the head drives m_data/m_valid. It never overflows by construction, and a push and pop in the same cycle are both honoured.
- m_last is high on the beat whose word index is length−1.
- m_data is held stable while m_valid=1 and m_ready=0.
- Address arithmetic: modulo 2^`REG_SIZE` in the counter. Range handling is set by the Configuration macro.
- Reset (any state, mid-transfer included): FSM to IDLE, FIFO flushed, inflight read discarded. The reader never drives the memory's rst.

## Timing
- Reset values: busy=0, done=0, err=0, mem_address=0, m_valid=0, m_data=0, m_last=0.
- start high in cycle 0:
  - mem_address=base in cycle 1;
  - mem_data valid in cycle 2;
  - first m_valid in cycle 3.
- busy rises in cycle 1 and falls in the same cycle done pulses.
- With m_ready held high, beats are sent on consecutive cycles. A transfer of N words ends with done in cycle N+3.
- done pulses the cycle after the m_last beat is accepted.
- m_ready low for K cycles delays the stream by exactly K cycles; no word is dropped or repeated.

## Configuration
- Macro `E_MEM_READER_WRAP_EN`.
- Defined: addresses wrap from `MEM_SIZE`−1 to 0, and any base/length is accepted.
- Undefined: a command with base_addr ≥ `MEM_SIZE` or base_addr+length > `MEM_SIZE` is rejected. err pulses in cycle 1, busy stays 0, and there is no done.

## Structure
- `REG_SIZE` and `MEM_SIZE` come from package_fpga.v. Add reader state encodings (IDLE/RUN/DRAIN) and FIFO depth constant 2 there.
- One sub-module, `e_mem_skid_fifo`: 2-entry FIFO with push/pop, plus occupancy output used by the issue rule.
- The testbench instantiates `E_MEM` with a known image_data.mem (word i = i+0x10) as the responder.

## Test plan
- Reset, then base=0, length=4, m_ready=1: mem_address 0..3 in cycles 1..4; m_data 0x10..0x13 in cycles 3..6; m_last in cycle 6; done in cycle 7.
- base=8, length=6, m_ready toggling 1/0 each cycle: six beats 0x18..0x1D in order, no gaps beyond the stalls, data stable while stalled.
- length=0: done pulses in cycle 1, m_valid never rises, busy stays 0.
- Without `E_MEM_READER_WRAP_EN`: base=`MEM_SIZE`−2, length=4 gives err in cycle 1 and no beats. With it defined: words `MEM_SIZE`−2, `MEM_SIZE`−1, 0, 1 are sent.
- rst asserted on the third beat of a length-10 transfer: next cycle all outputs are at reset values. A following length-2 command from base 0 gives exactly 0x10, 0x11.
- start re-pulsed mid-transfer: it is ignored, the original transfer completes unchanged, and there is one done.
